auto_burst_scheduler: RTL and testbench

AUTO_BURST_SCHEDULER -- requirements
Module: auto_burst_scheduler

---
 rtl/auto_burst_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_auto_burst_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_burst_scheduler.sv
// auto_burst_scheduler
// Schedules SDRAM bursts between a camera-side write FIFO and a display-side
// read FIFO. Write bursts start once a full burst of pixels is buffered, read
// bursts once the read FIFO has room for a full burst. When both kinds are
// ready, the scheduler alternates between them.
//
// Ports:
//   clk, rst_n                    sole clock, synchronous active-low reset
//   wfifo_wr_en/_wr_data          camera push into the write FIFO
//   wfifo_rd_en/_rd_data          SDRAM-side pop; data is registered (1-cycle latency)
//   rfifo_wr_en/_wr_data          SDRAM-side push into the read FIFO
//   rfifo_rd_en/_rd_data          display pop; data is registered (1-cycle latency)
//   wr_req, rd_req                burst requests, high for the whole burst
//   burst_addr                    start word address of the active burst (0 when idle)
//   burst_done                    one-cycle pulse that ends the active burst
//   rfifo_rd_ready                sticky: display may start reading
//   wfifo_ovf, rfifo_udf          sticky error flags

module abs_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = rd_en && (count != '0);
    // A full FIFO still accepts a push in the same cycle as a pop, so the
    // occupancy stays unchanged; the freed slot is the one being written.
    assign push_ok = wr_en && ((count != CNT_W'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok) begin
                rptr    <= rptr + 1'b1;
                rd_data <= mem[rptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// state    | meaning
// IDLE     | no burst active; arbitrate between write and read eligibility
// WR_BURST | write burst granted; wr_req high, burst_addr = wr_addr
// RD_BURST | read burst granted; rd_req high, burst_addr = rd_addr
module auto_burst_scheduler #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 512,
    parameter int BURST_LEN   = 256,
    parameter int ADDR_W      = 22,
    parameter int FRAME_WORDS = 76800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wfifo_wr_en,
    input  logic [DATA_W-1:0] wfifo_wr_data,
    input  logic              wfifo_rd_en,
    output logic [DATA_W-1:0] wfifo_rd_data,
    input  logic              rfifo_wr_en,
    input  logic [DATA_W-1:0] rfifo_wr_data,
    input  logic              rfifo_rd_en,
    output logic [DATA_W-1:0] rfifo_rd_data,
    output logic              wr_req,
    output logic              rd_req,
    output logic [ADDR_W-1:0] burst_addr,
    input  logic              burst_done,
    output logic              rfifo_rd_ready,
    output logic              wfifo_ovf,
    output logic              rfifo_udf
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  rcnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr_inc;
    logic [ADDR_W-1:0] rd_addr_inc;
    logic              last_was_wr;
    logic              rd_enable;
    logic              we;
    logic              re;

    abs_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wfifo_wr_en),
        .wr_data (wfifo_wr_data),
        .rd_en   (wfifo_rd_en),
        .rd_data (wfifo_rd_data),
        .count   (wcnt)
    );

    abs_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rfifo_wr_en),
        .wr_data (rfifo_wr_data),
        .rd_en   (rfifo_rd_en),
        .rd_data (rfifo_rd_data),
        .count   (rcnt)
    );

    assign we = wcnt >= CNT_W'(BURST_LEN);
    assign re = rd_enable && ((CNT_W'(FIFO_DEPTH) - rcnt) >= CNT_W'(BURST_LEN));

    assign wr_addr_inc = wr_addr + ADDR_W'(BURST_LEN);
    assign rd_addr_inc = rd_addr + ADDR_W'(BURST_LEN);

    always_comb begin
        state_nxt  = state;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        burst_addr = '0;
        case (state)
            IDLE: begin
                // last_was_wr resets to 0, so a tie straight after reset goes to write.
                if (we && re)
                    state_nxt = last_was_wr ? RD_BURST : WR_BURST;
                else if (we)
                    state_nxt = WR_BURST;
                else if (re)
                    state_nxt = RD_BURST;
            end
            WR_BURST: begin
                wr_req     = 1'b1;
                burst_addr = wr_addr;
                if (burst_done)
                    state_nxt = IDLE;
            end
            RD_BURST: begin
                rd_req     = 1'b1;
                burst_addr = rd_addr;
                if (burst_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_addr        <= '0;
            rd_addr        <= '0;
            last_was_wr    <= 1'b0;
            rd_enable      <= 1'b0;
            rfifo_rd_ready <= 1'b0;
            wfifo_ovf      <= 1'b0;
            rfifo_udf      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == WR_BURST)
                last_was_wr <= 1'b1;
            if (state == IDLE && state_nxt == RD_BURST)
                last_was_wr <= 1'b0;
            if (state == WR_BURST && burst_done) begin
                wr_addr   <= (wr_addr_inc == ADDR_W'(FRAME_WORDS)) ? '0 : wr_addr_inc;
                rd_enable <= 1'b1;
            end
            if (state == RD_BURST && burst_done)
                rd_addr <= (rd_addr_inc == ADDR_W'(FRAME_WORDS)) ? '0 : rd_addr_inc;
            if (rd_enable && (rcnt >= CNT_W'(BURST_LEN)))
                rfifo_rd_ready <= 1'b1;
            // A full write FIFO only drops the push when no pop frees a slot.
            if (wfifo_wr_en && (wcnt == CNT_W'(FIFO_DEPTH)) && !wfifo_rd_en)
                wfifo_ovf <= 1'b1;
            if (rfifo_rd_en && (rcnt == '0))
                rfifo_udf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_auto_burst_scheduler.sv
// Testbench for auto_burst_scheduler, built with FRAME_WORDS=1024 so the
// address wrap is reachable in a short run.
module tb_auto_burst_scheduler;
    localparam int DW    = 16;
    localparam int DEPTH = 512;
    localparam int BL    = 256;
    localparam int AW    = 22;
    localparam int FW    = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wfifo_wr_en = 1'b0;
    logic [DW-1:0] wfifo_wr_data = '0;
    logic          wfifo_rd_en = 1'b0;
    logic [DW-1:0] wfifo_rd_data;
    logic          rfifo_wr_en = 1'b0;
    logic [DW-1:0] rfifo_wr_data = '0;
    logic          rfifo_rd_en = 1'b0;
    logic [DW-1:0] rfifo_rd_data;
    logic          wr_req;
    logic          rd_req;
    logic [AW-1:0] burst_addr;
    logic          burst_done = 1'b0;
    logic          rfifo_rd_ready;
    logic          wfifo_ovf;
    logic          rfifo_udf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
    } grant_t;

    logic [DW-1:0] wq[$];
    logic [DW-1:0] rq[$];
    grant_t        gq[$];
    logic [DW-1:0] last_w = '0;
    logic [DW-1:0] last_r = '0;

    auto_burst_scheduler #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .ADDR_W(AW), .FRAME_WORDS(FW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wfifo_wr_en    (wfifo_wr_en),
        .wfifo_wr_data  (wfifo_wr_data),
        .wfifo_rd_en    (wfifo_rd_en),
        .wfifo_rd_data  (wfifo_rd_data),
        .rfifo_wr_en    (rfifo_wr_en),
        .rfifo_wr_data  (rfifo_wr_data),
        .rfifo_rd_en    (rfifo_rd_en),
        .rfifo_rd_data  (rfifo_rd_data),
        .wr_req         (wr_req),
        .rd_req         (rd_req),
        .burst_addr     (burst_addr),
        .burst_done     (burst_done),
        .rfifo_rd_ready (rfifo_rd_ready),
        .wfifo_ovf      (wfifo_ovf),
        .rfifo_udf      (rfifo_udf)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic gq_add(input bit is_wr, input logic [AW-1:0] addr);
        grant_t g;
        g.is_wr = is_wr;
        g.addr  = addr;
        gq.push_back(g);
    endtask

    // Waits for the next request and compares it with the head of the grant queue.
    task automatic wait_grant(input string name);
        grant_t g;
        int     n;
        g = gq.pop_front();
        n = 0;
        while (!(wr_req || rd_req) && n < 64) begin
            tick;
            n++;
        end
        checks++;
        if (!(wr_req || rd_req)) begin
            errors++;
            $display("FAIL %s_timeout: no request within 64 cycles", name);
            return;
        end
        checks++;
        if ({wr_req, rd_req} !== {g.is_wr, !g.is_wr}) begin
            errors++;
            $display("FAIL %s_type: wr_req/rd_req=%b%b expected %b%b", name, wr_req, rd_req, g.is_wr, !g.is_wr);
        end
        checks++;
        if (burst_addr !== g.addr) begin
            errors++;
            $display("FAIL %s_addr: burst_addr=%0d expected %0d", name, burst_addr, g.addr);
        end
    endtask

    task automatic finish_burst(input string name);
        burst_done = 1'b1;
        tick;
        burst_done = 1'b0;
        checks++;
        if ({wr_req, rd_req} !== 2'b00 || burst_addr !== '0) begin
            errors++;
            $display("FAIL %s_idle: wr_req=%b rd_req=%b burst_addr=%0d expected 0 0 0", name, wr_req, rd_req, burst_addr);
        end
    endtask

    task automatic pop_w(input int n, input string name);
        logic [DW-1:0] exp;
        for (int i = 0; i < n; i++) begin
            wfifo_rd_en = 1'b1;
            tick;
            exp = wq.pop_front();
            checks++;
            if (wfifo_rd_data !== exp) begin
                errors++;
                $display("FAIL %s_wdata[%0d]: wfifo_rd_data=%h expected %h", name, i, wfifo_rd_data, exp);
            end
            last_w = exp;
        end
        wfifo_rd_en = 1'b0;
    endtask

    task automatic pop_r(input int n, input string name);
        logic [DW-1:0] exp;
        for (int i = 0; i < n; i++) begin
            rfifo_rd_en = 1'b1;
            tick;
            exp = rq.pop_front();
            checks++;
            if (rfifo_rd_data !== exp) begin
                errors++;
                $display("FAIL %s_rdata[%0d]: rfifo_rd_data=%h expected %h", name, i, rfifo_rd_data, exp);
            end
            last_r = exp;
        end
        rfifo_rd_en = 1'b0;
    endtask

    task automatic push_w(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wfifo_wr_en   = 1'b1;
            wfifo_wr_data = base + DW'(i);
            wq.push_back(wfifo_wr_data);
            tick;
        end
        wfifo_wr_en = 1'b0;
    endtask

    task automatic push_r(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            rfifo_wr_en   = 1'b1;
            rfifo_wr_data = base + DW'(i);
            rq.push_back(rfifo_wr_data);
            tick;
        end
        rfifo_wr_en = 1'b0;
    endtask

    // Pushes BL words into an empty write FIFO with rd_enable clear and
    // checks that the write request rises exactly one cycle after the last push.
    task automatic push_to_threshold(input logic [DW-1:0] base, input string name);
        for (int i = 0; i < BL - 1; i++) begin
            wfifo_wr_en   = 1'b1;
            wfifo_wr_data = base + DW'(i);
            wq.push_back(wfifo_wr_data);
            tick;
            checks++;
            if (wr_req !== 1'b0 || rd_req !== 1'b0) begin
                errors++;
                $display("FAIL %s_below: after %0d words wr_req=%b rd_req=%b expected 0 0", name, i + 1, wr_req, rd_req);
            end
        end
        wfifo_wr_data = base + DW'(BL - 1);
        wq.push_back(wfifo_wr_data);
        tick;
        wfifo_wr_en = 1'b0;
        checks++;
        if (wr_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: wr_req=%b expected 0 in the cycle the count reaches %0d", name, wr_req, BL);
        end
        tick;
        checks++;
        if (wr_req !== 1'b1 || rd_req !== 1'b0 || burst_addr !== '0) begin
            errors++;
            $display("FAIL %s_grant: wr_req=%b rd_req=%b burst_addr=%0d expected 1 0 0", name, wr_req, rd_req, burst_addr);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        checks++;
        if ({wr_req, rd_req, rfifo_rd_ready, wfifo_ovf, rfifo_udf} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: req/ready/ovf/udf=%b expected 00000",
                     {wr_req, rd_req, rfifo_rd_ready, wfifo_ovf, rfifo_udf});
        end
        checks++;
        if (burst_addr !== '0 || wfifo_rd_data !== '0 || rfifo_rd_data !== '0) begin
            errors++;
            $display("FAIL reset_data: burst_addr=%0d wfifo_rd_data=%h rfifo_rd_data=%h expected 0 0 0",
                     burst_addr, wfifo_rd_data, rfifo_rd_data);
        end
        rst_n = 1'b1;
        repeat (3) tick;
        checks++;
        if ({wr_req, rd_req, rfifo_rd_ready, wfifo_ovf, rfifo_udf} !== 5'b0) begin
            errors++;
            $display("FAIL after_reset_flags: req/ready/ovf/udf=%b expected 00000",
                     {wr_req, rd_req, rfifo_rd_ready, wfifo_ovf, rfifo_udf});
        end
    endtask

    task automatic test_wr_threshold;
        push_to_threshold(16'h1000, "thresh");
        pop_w(BL, "thresh");
        finish_burst("thresh");
    endtask

    // First completed write enables reads; with the write FIFO held full and
    // the read FIFO empty, grants alternate and both addresses wrap at FW.
    task automatic test_round_robin;
        gq_add(1'b0, 22'd0);
        wait_grant("rr_first_rd");
        push_w(DEPTH, 16'h2000);
        finish_burst("rr_first_rd");
        for (int i = 1; i <= 4; i++) begin
            gq_add(1'b1, AW'((i * BL) % FW));
            gq_add(1'b0, AW'((i * BL) % FW));
        end
        while (gq.size() > 0) begin
            wait_grant("rr");
            finish_burst("rr");
        end
    endtask

    task automatic test_reset_mid_burst;
        gq_add(1'b1, 22'd256);
        wait_grant("midrst_wr");
        rst_n = 1'b0;
        tick;
        checks++;
        if ({wr_req, rd_req, rfifo_rd_ready} !== 3'b000 || burst_addr !== '0) begin
            errors++;
            $display("FAIL midrst_out: wr_req=%b rd_req=%b ready=%b burst_addr=%0d expected 0 0 0 0",
                     wr_req, rd_req, rfifo_rd_ready, burst_addr);
        end
        rst_n = 1'b1;
        wq.delete();
        rq.delete();
        wfifo_rd_en = 1'b1;
        tick;
        wfifo_rd_en = 1'b0;
        checks++;
        if (wfifo_rd_data !== '0) begin
            errors++;
            $display("FAIL midrst_wcount: pop after reset gave %h expected 0000 (FIFO empty)", wfifo_rd_data);
        end
        for (int i = 0; i < 20; i++) begin
            tick;
            checks++;
            if (wr_req !== 1'b0 || rd_req !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet: cycle %0d wr_req=%b rd_req=%b expected 0 0", i, wr_req, rd_req);
            end
        end
        push_to_threshold(16'h3000, "midrst");

        push_w(DEPTH - BL, 16'h4000);
        checks++;
        if (wfifo_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_full: wfifo_ovf=%b expected 0 with exactly %0d words", wfifo_ovf, DEPTH);
        end
        wfifo_wr_en   = 1'b1;
        wfifo_wr_data = 16'hdead;
        tick;
        wfifo_wr_en = 1'b0;
        tick;
        checks++;
        if (wfifo_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: wfifo_ovf=%b expected 1 after push %0d", wfifo_ovf, DEPTH + 1);
        end
        pop_w(DEPTH, "ovf");
        wfifo_rd_en = 1'b1;
        tick;
        wfifo_rd_en = 1'b0;
        checks++;
        if (wfifo_rd_data !== last_w) begin
            errors++;
            $display("FAIL wfifo_empty_hold: wfifo_rd_data=%h expected %h", wfifo_rd_data, last_w);
        end
        checks++;
        if (wfifo_ovf !== 1'b1 || rfifo_udf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: wfifo_ovf=%b rfifo_udf=%b expected 1 0", wfifo_ovf, rfifo_udf);
        end
        finish_burst("ovf");
    endtask

    task automatic test_read_ready;
        gq_add(1'b0, 22'd0);
        wait_grant("ready_rd0");
        push_r(BL, 16'h5000);
        checks++;
        if (rfifo_rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_early: rfifo_rd_ready=%b expected 0 in the cycle the count reaches %0d", rfifo_rd_ready, BL);
        end
        tick;
        checks++;
        if (rfifo_rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_set: rfifo_rd_ready=%b expected 1", rfifo_rd_ready);
        end
        finish_burst("ready_rd0");

        gq_add(1'b0, 22'd256);
        wait_grant("ready_rd256");
        pop_r(BL, "drain");
        checks++;
        if (rfifo_rd_ready !== 1'b1 || rfifo_udf !== 1'b0) begin
            errors++;
            $display("FAIL ready_sticky: rfifo_rd_ready=%b rfifo_udf=%b expected 1 0", rfifo_rd_ready, rfifo_udf);
        end
        rfifo_rd_en = 1'b1;
        tick;
        rfifo_rd_en = 1'b0;
        checks++;
        if (rfifo_rd_data !== last_r) begin
            errors++;
            $display("FAIL rfifo_empty_hold: rfifo_rd_data=%h expected %h", rfifo_rd_data, last_r);
        end
        tick;
        checks++;
        if (rfifo_udf !== 1'b1) begin
            errors++;
            $display("FAIL udf_set: rfifo_udf=%b expected 1", rfifo_udf);
        end

        // Leave less than a burst of free space so nothing is eligible.
        push_r(BL + 1, 16'h6000);
        finish_burst("ready_rd256");
        for (int i = 0; i < 10; i++) begin
            if (i == 4)
                burst_done = 1'b1;
            tick;
            burst_done = 1'b0;
            checks++;
            if (wr_req !== 1'b0 || rd_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_done: cycle %0d wr_req=%b rd_req=%b expected 0 0", i, wr_req, rd_req);
            end
        end
        pop_r(2, "reopen");
        gq_add(1'b0, 22'd512);
        wait_grant("ready_rd512");
        finish_burst("ready_rd512");
    endtask

    initial begin
        test_reset;
        test_wr_threshold;
        test_round_robin;
        test_reset_mid_burst;
        test_read_ready;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
